// File: rtl/ascon_sigma_inv.sv
// Iterative inverse of the Ascon linear layer Sigma_imm on one 64-bit lane.
// Sigma^-1 is Sigma^63, built as six squarings Sigma^(2^k); RPC squarings are applied per clock.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high once out of reset
// RUN   | applying squaring rounds, count tracks rounds done
// DONE  | result (or unchanged lane with err) held until out_ready
module ascon_sigma_inv #(
    parameter int RPC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [4:0]  imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] rd_lo,
    output logic [31:0] rd_hi,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  count, count_nxt;
    logic [63:0] lane, lane_nxt, lane_tmp;
    logic [2:0]  sel, sel_nxt;
    logic        err_q, err_nxt;
    logic        live;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [5:0] n);
        logic [127:0] dbl;
        dbl = {x, x} >> n;
        return dbl[63:0];
    endfunction

    function automatic logic [11:0] rot_amounts(input logic [2:0] s);
        case (s)
            3'd0:    return {6'd19, 6'd28};
            3'd1:    return {6'd61, 6'd39};
            3'd2:    return {6'd1,  6'd6};
            3'd3:    return {6'd10, 6'd17};
            default: return {6'd7,  6'd41};
        endcase
    endfunction

    // Squaring Sigma^(2^k): rotation amounts doubled k times, wrapped to 6 bits (mod 64).
    function automatic logic [63:0] sq_round(input logic [63:0] x, input logic [2:0] s,
                                             input logic [2:0] k);
        logic [5:0] a, b, ak, bk;
        {a, b} = rot_amounts(s);
        ak = a << k;
        bk = b << k;
        return x ^ rotr64(x, ak) ^ rotr64(x, bk);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= 3'd0;
            lane  <= 64'd0;
            sel   <= 3'd0;
            err_q <= 1'b0;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            lane  <= lane_nxt;
            sel   <= sel_nxt;
            err_q <= err_nxt;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        lane_nxt  = lane;
        sel_nxt   = sel;
        err_nxt   = err_q;
        lane_tmp  = lane;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    lane_nxt  = {rs2, rs1};
                    count_nxt = 3'd0;
                    if (imm > 5'd4) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        sel_nxt   = imm[2:0];
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                for (int j = 0; j < RPC; j++) begin
                    lane_tmp = sq_round(lane_tmp, sel, count + 3'(j));
                end
                lane_nxt  = lane_tmp;
                count_nxt = count + 3'(RPC);
                if (count_nxt == 3'd6) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // live holds in_ready low until the first edge after reset release.
    assign in_ready  = (state == IDLE) && live;
    assign out_valid = (state == DONE);
    assign rd_lo     = lane[31:0];
    assign rd_hi     = lane[63:32];
    assign err       = err_q;

endmodule

// File: tb/tb_ascon_sigma_inv.sv
// Scoreboard bench for ascon_sigma_inv: four instances with RPC 1, 2, 3, 6 share the data inputs,
// requests push expected results, a negedge monitor pops and compares on each output handshake.
module tb_ascon_sigma_inv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  in_valid_v, in_ready_v, out_valid_v, out_ready_v, err_v;
    logic [31:0] rs1, rs2;
    logic [4:0]  imm;
    logic [31:0] rd_lo_v [4];
    logic [31:0] rd_hi_v [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ascon_sigma_inv #(.RPC((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .rs1       (rs1),
            .rs2       (rs2),
            .imm       (imm),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .rd_lo     (rd_lo_v[g]),
            .rd_hi     (rd_hi_v[g]),
            .err       (err_v[g])
        );
    end

    typedef struct {
        int          dut;
        logic [63:0] data;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rpc_of(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return 6;
        endcase
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Forward Ascon linear layer, used to build inputs whose inverse is known.
    function automatic logic [63:0] sigma(input logic [63:0] x, input int i);
        int a, b;
        case (i)
            0:       begin a = 19; b = 28; end
            1:       begin a = 61; b = 39; end
            2:       begin a = 1;  b = 6;  end
            3:       begin a = 10; b = 17; end
            default: begin a = 7;  b = 41; end
        endcase
        return x ^ rotr(x, a) ^ rotr(x, b);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int d, input logic [63:0] x_in, input logic [4:0] im,
                         input logic [63:0] exp_data, input logic exp_err, output int waits);
        exp_t t;
        waits = 0;
        rs1 = x_in[31:0];
        rs2 = x_in[63:32];
        imm = im;
        in_valid_v[d] = 1'b1;
        while (!in_ready_v[d] && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready_v[d]) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: dut %0d never ready", d);
            in_valid_v[d] = 1'b0;
            return;
        end
        t.dut  = d;
        t.data = exp_data;
        t.err  = exp_err;
        t.acc  = cyc;
        t.lat  = exp_err ? 1 : 6 / rpc_of(d) + 1;
        sb.push_back(t);
        @(posedge clk);
        @(negedge clk);
        in_valid_v[d] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL result_timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: latency at the rising edge of out_valid, data and err at each handshake.
    initial begin
        logic [3:0] prev;
        prev = 4'b0;
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 4; d++) begin
                if (out_valid_v[d] && !prev[d]) begin
                    if (sb.size() == 0 || sb[0].dut != d) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_valid: dut %0d raised out_valid", d);
                    end else begin
                        check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                    end
                end
                if (out_valid_v[d] && out_ready_v[d] && sb.size() > 0 && sb[0].dut == d) begin
                    check("rd", {rd_hi_v[d], rd_lo_v[d]}, sb[0].data);
                    check("err", 64'(err_v[d]), 64'(sb[0].err));
                    void'(sb.pop_front());
                end
            end
            prev = out_valid_v;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [63:0] x, xa, xb;
        int          im;

        in_valid_v  = 4'b0;
        out_ready_v = 4'b1111;
        rs1 = 32'd0;
        rs2 = 32'd0;
        imm = 5'd0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready_v[0]), 64'd0);
        check("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("rst_err", 64'(err_v[0]), 64'd0);
        check("rst_rd", {rd_hi_v[0], rd_lo_v[0]}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(in_ready_v[0]), 64'd1);

        issue(0, {32'h0000_2010, 32'h0000_0001}, 5'd0, 64'h1, 1'b0, w);
        wait_idle();
        issue(0, 64'h0, 5'd2, 64'h0, 1'b0, w);
        wait_idle();
        issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
        wait_idle();

        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < ((d == 0) ? 1000 : 100); i++) begin
                x  = {$urandom, $urandom};
                im = $urandom_range(0, 4);
                issue(d, sigma(x, im), 5'(im), x, 1'b0, w);
                wait_idle();
            end
        end

        issue(0, 64'h1234_5678_9ABC_DEF0, 5'd7, 64'h1234_5678_9ABC_DEF0, 1'b1, w);
        wait_idle();
        x = 64'h0F1E_2D3C_4B5A_6978;
        issue(0, sigma(x, 3), 5'd3, x, 1'b0, w);
        wait_idle();

        xa = 64'hDEAD_BEEF_0123_4567;
        xb = 64'h8899_AABB_CCDD_EEFF;
        out_ready_v[0] = 1'b0;
        issue(0, sigma(xa, 1), 5'd1, xa, 1'b0, w);
        w = 0;
        while (!out_valid_v[0] && w < 20) begin
            @(negedge clk);
            w++;
        end
        rs1 = sigma(xb, 4) >> 0;
        rs2 = 32'(sigma(xb, 4) >> 32);
        imm = 5'd4;
        in_valid_v[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall_rd", {rd_hi_v[0], rd_lo_v[0]}, xa);
            check("stall_valid", 64'(out_valid_v[0]), 64'd1);
            check("stall_err", 64'(err_v[0]), 64'd0);
            check("stall_in_ready", 64'(in_ready_v[0]), 64'd0);
            @(negedge clk);
        end
        out_ready_v[0] = 1'b1;
        issue(0, sigma(xb, 4), 5'd4, xb, 1'b0, w);
        check("pending_accept_wait", 64'(w), 64'd1);
        wait_idle();

        x = 64'hA5A5_0000_FFFF_1234;
        issue(0, sigma(x, 2), 5'd2, x, 1'b0, w);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("abort_in_ready", 64'(in_ready_v[0]), 64'd0);
        check("abort_rd", {rd_hi_v[0], rd_lo_v[0]}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_abort", 64'(in_ready_v[0]), 64'd1);
        x = 64'h0123_4567_89AB_CDEF;
        issue(0, sigma(x, 0), 5'd0, x, 1'b0, w);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
